// File: rtl/muldiv_iter.sv
// Iterative MIPS mult/multu/div/divu unit: radix-2 shift-add multiply or restoring divide,
// one bit per cycle, start/busy/done handshake driving the HI/LO write-back.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             we_hi,
  output logic             we_lo,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  // b_q: multiplicand or divisor magnitude; {hi_q, lo_q}: product accumulator, or
  // partial remainder / dividend-shifting-into-quotient for divide.
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_out_d, lo_out_d;
  logic             dbz_d;

  logic               accept, is_signed, a_neg, b_neg, b_zero, div_ge;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    accept    = ((state_q == StIdle) || (state_q == StDone)) && start && !flush;
    is_signed = ~op[0];
    a_neg     = is_signed & srcA[WIDTH-1];
    b_neg     = is_signed & srcB[WIDTH-1];
    a_mag     = a_neg ? -srcA : srcA;
    b_mag     = b_neg ? -srcB : srcB;
    b_zero    = op[1] && (srcB == '0);
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = div_shift >= {1'b0, b_q};
    prod      = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_out_d  = hi_out;
    lo_out_d  = lo_out;
    dbz_d     = div_by_zero;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          is_div_d  = op[1];
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          cnt_d     = CntW'(WIDTH);
          hi_d      = '0;
          b_d       = op[1] ? b_mag : a_mag;
          lo_d      = op[1] ? a_mag : b_mag;
          if (b_zero) begin
            state_d  = StDone;
            hi_out_d = srcA;
            lo_out_d = '1;
            dbz_d    = 1'b1;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        cnt_d = cnt_q - CntW'(1);
        if (is_div_q) begin
          hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], div_ge};
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CntW'(1)) state_d = StSign;
      end
      StSign: begin
        state_d = StDone;
        dbz_d   = 1'b0;
        if (is_div_q) begin
          lo_out_d = neg_q ? -lo_q : lo_q;
          hi_out_d = neg_rem_q ? -hi_q : hi_q;
        end else begin
          hi_out_d = prod[2*WIDTH-1:WIDTH];
          lo_out_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort leaves the visible result exactly as it was.
    if (flush) begin
      state_d  = StIdle;
      hi_out_d = hi_out;
      lo_out_d = lo_out;
      dbz_d    = div_by_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      hi_out      <= '0;
      lo_out      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      neg_q       <= neg_d;
      neg_rem_q   <= neg_rem_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      hi_out      <= hi_out_d;
      lo_out      <= lo_out_d;
      div_by_zero <= dbz_d;
    end
  end

  assign busy  = (state_q == StCalc) || (state_q == StSign);
  assign done  = (state_q == StDone);
  assign we_hi = done;
  assign we_lo = done;

endmodule
